// File: rtl/nco_pkg.sv
// +----------------------------------------------------------------------------+
// | nco_pkg: shared waveform codes, phase constants and reference sine table.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package nco_pkg;

   typedef enum logic [2:0] {
      SINE     = 3'd0,
      COSINE   = 3'd1,
      SQUARE   = 3'd2,
      TRIANGLE = 3'd3,
      SAWTOOTH = 3'd4
   } wave_sel_e;

   localparam int PHASE_BITS         = 5;
   localparam int SAMPLES_PER_PERIOD = 32;

   // 128 + round(127 * sin(2*pi*k/32)), offset-binary at 8 bits
   localparam logic [7:0] SINE_TABLE [0:SAMPLES_PER_PERIOD-1] = '{
      8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
      8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
      8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
      8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
   };

endpackage

`default_nettype wire

// File: rtl/nco_wave_gen_if.sv
// +----------------------------------------------------------------------------+
// | nco_wave_gen_if: waveform select and sample/period-start return path.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface nco_wave_gen_if #(
   parameter int SELECT_WIDTH = 3,
   parameter int WAVE_WIDTH   = 8
);
   logic [SELECT_WIDTH-1:0] signal_out;
   logic [WAVE_WIDTH-1:0]   wave_out;
   logic                    period_start;

   modport master (output signal_out, input wave_out, input period_start);
   modport slave  (input signal_out, output wave_out, output period_start);
endinterface

`default_nettype wire

// File: rtl/nco_sine_rom.sv
// +----------------------------------------------------------------------------+
// | nco_sine_rom: combinational 32-entry sine lookup scaled to WAVE_WIDTH.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nco_sine_rom
   import nco_pkg::*;
#(
   parameter int WAVE_WIDTH = 8
) (
   input  wire logic [PHASE_BITS-1:0] addr,
   output logic      [WAVE_WIDTH-1:0] data
);
   localparam int SHIFT = WAVE_WIDTH - 8;

   assign data = WAVE_WIDTH'(SINE_TABLE[addr]) << SHIFT;
endmodule

`default_nettype wire

// File: rtl/nco_wave_gen.sv
// +----------------------------------------------------------------------------+
// | nco_wave_gen: select-driven NCO, one registered sample per clock.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nco_wave_gen
   import nco_pkg::*;
#(
   parameter int SELECT_WIDTH = 3,
   parameter int WAVE_WIDTH   = 8
) (
   input wire logic     clk,
   input wire logic     rst,
   nco_wave_gen_if.slave bus
);
   localparam int                    SHIFT    = WAVE_WIDTH - 8;
   localparam logic [WAVE_WIDTH-1:0] MIDSCALE = {1'b1, {(WAVE_WIDTH-1){1'b0}}};

   logic [SELECT_WIDTH-1:0] sel_q, sel_d;
   logic [PHASE_BITS-1:0]   phase_q, phase_d;
   logic [WAVE_WIDTH-1:0]   wave_q, wave_d;
   logic                    period_start_q, period_start_d;

   logic [PHASE_BITS-1:0]   rom_addr;
   logic [WAVE_WIDTH-1:0]   rom_data;
   logic [3:0]              tri_idx;

   // Cosine is the sine table read a quarter period ahead
   assign rom_addr = (sel_q == SELECT_WIDTH'(COSINE)) ? phase_q + PHASE_BITS'(8) : phase_q;
   // Falling half of the triangle: 31-p equals the inverted low nibble
   assign tri_idx  = phase_q[4] ? ~phase_q[3:0] : phase_q[3:0];

   nco_sine_rom #(
      .WAVE_WIDTH (WAVE_WIDTH)
   ) u_sine_rom (
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      sel_d          = sel_q;
      phase_d        = phase_q + PHASE_BITS'(1);
      wave_d         = MIDSCALE;
      period_start_d = (phase_q == '0);

      if (bus.signal_out != sel_q) begin
         sel_d   = bus.signal_out;
         phase_d = '0;
      end

      if (sel_q < SELECT_WIDTH'(5)) begin
         case (sel_q[2:0])
            SINE, COSINE: wave_d = rom_data;
            SQUARE:       wave_d = phase_q[4] ? '0 : '1;
            TRIANGLE:     wave_d = WAVE_WIDTH'({tri_idx, 4'b0000}) << SHIFT;
            SAWTOOTH:     wave_d = WAVE_WIDTH'({phase_q, 3'b000}) << SHIFT;
            default:      wave_d = MIDSCALE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q          <= '0;
         phase_q        <= '0;
         wave_q         <= MIDSCALE;
         period_start_q <= 1'b0;
      end else begin
         sel_q          <= sel_d;
         phase_q        <= phase_d;
         wave_q         <= wave_d;
         period_start_q <= period_start_d;
      end
   end

   assign bus.wave_out     = wave_q;
   assign bus.period_start = period_start_q;
endmodule

`default_nettype wire

// File: tb/tb_nco_wave_gen.sv
// +----------------------------------------------------------------------------+
// | tb_nco_wave_gen: directed self-checking bench for nco_wave_gen.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nco_wave_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] rom_ref [0:31] = '{
      8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
      8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
      8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
      8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
   };

   nco_wave_gen_if #(.SELECT_WIDTH(3), .WAVE_WIDTH(8)) bus ();

   nco_wave_gen #(
      .SELECT_WIDTH (3),
      .WAVE_WIDTH   (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.signal_out = 3'd0;
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.wave_out !== 8'd128 || bus.period_start !== 1'b0) begin
         $display("FAIL reset_async: wave=%0d ps=%b expected wave=128 ps=0", bus.wave_out, bus.period_start);
         n_err++;
      end
      tick();
      tick();
      n_vec++;
      if (bus.wave_out !== 8'd128 || bus.period_start !== 1'b0) begin
         $display("FAIL reset_held: wave=%0d ps=%b expected wave=128 ps=0", bus.wave_out, bus.period_start);
         n_err++;
      end
      rst = 1'b0;
   endtask

   // Select 0 held from reset release: cycle k carries ROM[(k-1)%32]
   task automatic test_sine();
      for (int k = 1; k <= 40; k++) begin
         tick();
         n_vec++;
         if (bus.wave_out !== rom_ref[(k-1)%32] || bus.period_start !== (((k-1)%32) == 0)) begin
            $display("FAIL sine cycle %0d: wave=%0d ps=%b expected wave=%0d ps=%b",
                     k, bus.wave_out, bus.period_start, rom_ref[(k-1)%32], (((k-1)%32) == 0));
            n_err++;
         end
      end
   endtask

   task automatic test_square();
      logic [7:0] exp_w;
      bus.signal_out = 3'd2;
      tick();
      for (int j = 1; j <= 33; j++) begin
         tick();
         exp_w = (j <= 16 || j == 33) ? 8'd255 : 8'd0;
         n_vec++;
         if (bus.wave_out !== exp_w || bus.period_start !== (j == 1 || j == 33)) begin
            $display("FAIL square N+%0d: wave=%0d ps=%b expected wave=%0d ps=%b",
                     j, bus.wave_out, bus.period_start, exp_w, (j == 1 || j == 33));
            n_err++;
         end
      end
   endtask

   task automatic test_triangle();
      logic [7:0] exp_w;
      bus.signal_out = 3'd3;
      tick();
      for (int j = 1; j <= 32; j++) begin
         tick();
         exp_w = (j <= 16) ? 8'((j-1) * 16) : 8'((32-j) * 16);
         n_vec++;
         if (bus.wave_out !== exp_w) begin
            $display("FAIL triangle N+%0d: wave=%0d expected %0d", j, bus.wave_out, exp_w);
            n_err++;
         end
      end
   endtask

   task automatic test_sawtooth();
      logic [7:0] exp_w;
      bus.signal_out = 3'd4;
      tick();
      for (int j = 1; j <= 34; j++) begin
         tick();
         exp_w = 8'(((j-1) % 32) * 8);
         n_vec++;
         if (bus.wave_out !== exp_w || bus.period_start !== (j == 1 || j == 33)) begin
            $display("FAIL sawtooth N+%0d: wave=%0d ps=%b expected wave=%0d ps=%b",
                     j, bus.wave_out, bus.period_start, exp_w, (j == 1 || j == 33));
            n_err++;
         end
      end
   endtask

   // Selects 1, 6, 1 on consecutive edges each restart the phase
   task automatic test_back_to_back();
      logic [2:0] sel_seq [0:3] = '{3'd1, 3'd6, 3'd1, 3'd1};
      logic [7:0] exp_w   [0:3] = '{8'd255, 8'd128, 8'd255, 8'd253};
      logic       exp_ps  [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
      bus.signal_out = sel_seq[0];
      tick();
      for (int j = 1; j <= 4; j++) begin
         if (j < 4) bus.signal_out = sel_seq[j];
         tick();
         n_vec++;
         if (bus.wave_out !== exp_w[j-1] || bus.period_start !== exp_ps[j-1]) begin
            $display("FAIL back_to_back step %0d: wave=%0d ps=%b expected wave=%0d ps=%b",
                     j, bus.wave_out, bus.period_start, exp_w[j-1], exp_ps[j-1]);
            n_err++;
         end
      end
   endtask

   task automatic test_reset_mid_period();
      logic [7:0] exp_w [0:2] = '{8'd128, 8'd153, 8'd177};
      bus.signal_out = 3'd0;
      tick();
      for (int j = 0; j < 4; j++) tick();
      n_vec++;
      if (bus.wave_out !== 8'd199) begin
         $display("FAIL pre_reset_sine: wave=%0d expected 199", bus.wave_out);
         n_err++;
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.wave_out !== 8'd128 || bus.period_start !== 1'b0) begin
         $display("FAIL reset_mid_period: wave=%0d ps=%b expected wave=128 ps=0", bus.wave_out, bus.period_start);
         n_err++;
      end
      tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         n_vec++;
         if (bus.wave_out !== exp_w[j] || bus.period_start !== (j == 0)) begin
            $display("FAIL post_reset cycle %0d: wave=%0d ps=%b expected wave=%0d ps=%b",
                     j + 1, bus.wave_out, bus.period_start, exp_w[j], (j == 0));
            n_err++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sine();
      test_square();
      test_triangle();
      test_sawtooth();
      test_back_to_back();
      test_reset_mid_period();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
